// File: rtl/mem_xbar_hs.sv
// mem_xbar_hs: handshaked memory crossbar between the core data port and
// NUM_TGT memory-mapped targets.
//
// Each request's word address is decoded into one of NUM_TGT inclusive
// regions. On a hit, the request is forwarded with a valid/ready handshake
// and the crossbar then waits for that target's response. On a decode miss,
// or when the timeout expires, the crossbar returns an error. Only one
// transaction is outstanding at a time.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_valid         core request valid
//   o_req_ready         core request ready (high only when idle)
//   i_addr/i_data       core word address and write data
//   i_wren/i_mask       write enable and byte mask
//   o_rsp_valid         one-cycle response pulse
//   o_rsp_data          read data (0 for writes and errors)
//   o_rsp_err           error flag, qualified by o_rsp_valid
//   o_err_cnt           saturating error counter
//   o_tgt_valid         per-target request valid (one-hot or zero)
//   i_tgt_ready         per-target request accept
//   o_tgt_addr/data/wren/mask  shared registered request fields
//   i_tgt_rsp_valid     per-target response valid
//   i_tgt_rsp_data      per-target read data, target i in slice i
module mem_xbar_hs #(
  parameter int NUM_TGT    = 2,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_TGT*ADDR_WIDTH-1:0] TGT_START = {30'h2000000, 30'h0000000},
  parameter logic [NUM_TGT*ADDR_WIDTH-1:0] TGT_LIMIT = {30'h20000FF, 30'h00003FF},
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_wren,
  input  logic [DATA_WIDTH/8-1:0]       i_mask,
  output logic                          o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic [7:0]                    o_err_cnt,
  output logic [NUM_TGT-1:0]            o_tgt_valid,
  input  logic [NUM_TGT-1:0]            i_tgt_ready,
  output logic [ADDR_WIDTH-1:0]         o_tgt_addr,
  output logic [DATA_WIDTH-1:0]         o_tgt_data,
  output logic                          o_tgt_wren,
  output logic [DATA_WIDTH/8-1:0]       o_tgt_mask,
  input  logic [NUM_TGT-1:0]            i_tgt_rsp_valid,
  input  logic [NUM_TGT*DATA_WIDTH-1:0] i_tgt_rsp_data
);

  localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TMO = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  state_e                  state_q;
  logic [SEL_W-1:0]        sel_q;
  logic [CNT_W-1:0]        tmo_q;
  logic [NUM_TGT-1:0]      tgt_valid_q;
  logic [ADDR_WIDTH-1:0]   tgt_addr_q;
  logic [DATA_WIDTH-1:0]   tgt_data_q;
  logic                    tgt_wren_q;
  logic [DATA_WIDTH/8-1:0] tgt_mask_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_err_q;
  logic [7:0]              err_cnt_q;

  logic                    dec_hit;
  logic [SEL_W-1:0]        dec_sel;
  logic [NUM_TGT-1:0]      dec_onehot;
  logic                    sel_ready;
  logic                    sel_rsp_vld;
  logic [DATA_WIDTH-1:0]   sel_rsp_data;
  logic [CNT_W:0]          tmo_inc;
  logic                    tmo_expired;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Region decode: scanning from the highest index down lets the lowest
  // matching index overwrite the result, so the lowest index wins on overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (i_addr >= TGT_START[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          i_addr <= TGT_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  assign dec_onehot   = NUM_TGT'(1) << dec_sel;
  assign sel_ready    = i_tgt_ready[sel_q];
  assign sel_rsp_vld  = i_tgt_rsp_valid[sel_q];
  assign sel_rsp_data = i_tgt_rsp_data[sel_q*DATA_WIDTH +: DATA_WIDTH];

  // The counter counts cycles already spent in REQ/RSP. The transaction
  // aborts at the end of cycle number TIMEOUT unless it completes in that
  // same cycle.
  assign tmo_inc     = {1'b0, tmo_q} + 1'b1;
  assign tmo_expired = (tmo_inc >= TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      tmo_q       <= '0;
      tgt_valid_q <= '0;
      tgt_addr_q  <= '0;
      tgt_data_q  <= '0;
      tgt_wren_q  <= 1'b0;
      tgt_mask_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            tgt_addr_q <= i_addr;
            tgt_data_q <= i_data;
            tgt_wren_q <= i_wren;
            tgt_mask_q <= i_mask;
            sel_q      <= dec_sel;
            tmo_q      <= '0;
            if (dec_hit) begin
              tgt_valid_q <= dec_onehot;
              state_q     <= REQ;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              err_cnt_q   <= sat_inc(err_cnt_q);
              state_q     <= DONE;
            end
          end
        end
        REQ: begin
          tmo_q <= tmo_inc[CNT_W-1:0];
          // A ready in the final allowed cycle still leaves the transaction
          // pending, so the abort takes priority here.
          if (tmo_expired) begin
            tgt_valid_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            err_cnt_q   <= sat_inc(err_cnt_q);
            state_q     <= DONE;
          end else if (sel_ready) begin
            tgt_valid_q <= '0;
            state_q     <= RSP;
          end
        end
        RSP: begin
          tmo_q <= tmo_inc[CNT_W-1:0];
          if (sel_rsp_vld) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= tgt_wren_q ? '0 : sel_rsp_data;
            state_q     <= DONE;
          end else if (tmo_expired) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            err_cnt_q   <= sat_inc(err_cnt_q);
            state_q     <= DONE;
          end
        end
        DONE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_tgt_valid = tgt_valid_q;
  assign o_tgt_addr  = tgt_addr_q;
  assign o_tgt_data  = tgt_data_q;
  assign o_tgt_wren  = tgt_wren_q;
  assign o_tgt_mask  = tgt_mask_q;

endmodule

// File: tb/tb_mem_xbar_hs.sv
// Bench for mem_xbar_hs: two instances share all inputs. One uses the default
// timeout (255); the other uses a timeout of 4. Expected responses for both
// come from a transaction-level model of decode, handshake delays and timeout.
module tb_mem_xbar_hs;
  localparam int NT = 2, AW = 30, DW = 32, MW = 4;
  localparam int TLONG = 255, TSHORT = 4;
  localparam logic [AW-1:0] RS [NT] = '{30'h0000000, 30'h2000000};
  localparam logic [AW-1:0] RL [NT] = '{30'h00003FF, 30'h20000FF};

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic wren;
  logic [MW-1:0] mask;
  logic [NT-1:0] tgt_ready, tgt_rsp_valid;
  logic [NT*DW-1:0] tgt_rsp_data;

  logic ready_a, rv_a, re_a, twren_a;
  logic [DW-1:0] rd_a, tdata_a;
  logic [7:0] ec_a;
  logic [NT-1:0] tv_a;
  logic [AW-1:0] taddr_a;
  logic [MW-1:0] tmask_a;
  logic ready_b, rv_b, re_b, twren_b;
  logic [DW-1:0] rd_b, tdata_b;
  logic [7:0] ec_b;
  logic [NT-1:0] tv_b;
  logic [AW-1:0] taddr_b;
  logic [MW-1:0] tmask_b;

  always #5 clk = ~clk;

  mem_xbar_hs dut_a (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready_a),
    .i_addr(addr), .i_data(wdata), .i_wren(wren), .i_mask(mask),
    .o_rsp_valid(rv_a), .o_rsp_data(rd_a), .o_rsp_err(re_a), .o_err_cnt(ec_a),
    .o_tgt_valid(tv_a), .i_tgt_ready(tgt_ready), .o_tgt_addr(taddr_a),
    .o_tgt_data(tdata_a), .o_tgt_wren(twren_a), .o_tgt_mask(tmask_a),
    .i_tgt_rsp_valid(tgt_rsp_valid), .i_tgt_rsp_data(tgt_rsp_data));

  mem_xbar_hs #(.TIMEOUT(TSHORT)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready_b),
    .i_addr(addr), .i_data(wdata), .i_wren(wren), .i_mask(mask),
    .o_rsp_valid(rv_b), .o_rsp_data(rd_b), .o_rsp_err(re_b), .o_err_cnt(ec_b),
    .o_tgt_valid(tv_b), .i_tgt_ready(tgt_ready), .o_tgt_addr(taddr_b),
    .o_tgt_data(tdata_b), .o_tgt_wren(twren_b), .o_tgt_mask(tmask_b),
    .i_tgt_rsp_valid(tgt_rsp_valid), .i_tgt_rsp_data(tgt_rsp_data));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  exp_t qa[$], qb[$];
  int ecnt [2] = '{0, 0};

  // Plan for the target side of the current transaction.
  int plan_rd = 0, plan_rspd = 1;
  bit plan_never = 1'b0;
  bit force_spur = 1'b0;
  logic [31:0] plan_data = '0;
  logic cur_hit = 1'b0;
  int cur_sel = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  logic cur_wren = 1'b0;
  logic [MW-1:0] cur_mask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void decode(input logic [AW-1:0] a, output logic h, output int s);
    h = 1'b0;
    s = 0;
    for (int i = 0; i < NT; i++) begin
      if (!h && a >= RS[i] && a <= RL[i]) begin
        h = 1'b1;
        s = i;
      end
    end
  endfunction

  // Expected outcome for one instance: cycles spent in REQ+RSP is rd+1+rspd;
  // success if that fits within the timeout.
  function automatic exp_t model(input int k, input logic h, input logic w, input int rd,
                                 input int rspd, input bit never, input logic [31:0] rdat,
                                 input int c0);
    exp_t e;
    int t, tot;
    bit ok;
    t = (k == 0) ? TLONG : TSHORT;
    tot = rd + 1 + rspd;
    ok = h && !never && (tot <= t);
    e.data = (ok && !w) ? rdat : 32'h0;
    e.err = !ok;
    if (e.err && ecnt[k] < 255) ecnt[k] = ecnt[k] + 1;
    e.cnt = 8'(ecnt[k]);
    e.cyc = c0 + (!h ? 1 : (ok ? tot + 1 : t + 1));
    return e;
  endfunction

  task automatic issue(input logic [AW-1:0] a, input logic [31:0] d, input logic w,
                       input logic [MW-1:0] m, input int rd, input int rspd,
                       input bit never, input logic [31:0] rdat, input bit push);
    logic h;
    int s, to;
    decode(a, h, s);
    plan_rd = rd; plan_rspd = rspd; plan_never = never; plan_data = rdat;
    cur_hit = h; cur_sel = s; cur_addr = a; cur_data = d; cur_wren = w; cur_mask = m;
    to = 0;
    @(negedge clk);
    while (!ready_a && to < 1000) begin
      @(negedge clk);
      to++;
    end
    chk("req_ready_wait", ready_a, 1);
    req_valid = 1'b1; addr = a; wdata = d; wren = w; mask = m;
    if (push) begin
      qa.push_back(model(0, h, w, rd, rspd, never, rdat, cyc));
      qb.push_back(model(1, h, w, rd, rspd, never, rdat, cyc));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    addr = AW'($urandom); wdata = $urandom; wren = 1'($urandom); mask = MW'($urandom);
    if (push) begin
      to = 0;
      while ((qa.size() != 0 || qb.size() != 0) && to < 400) begin
        @(negedge clk);
        to++;
      end
      chk("rsp_drain", 64'(qa.size() + qb.size()), 0);
    end
  endtask

  task automatic chk_rsp(input string nm, input logic rv, input logic [31:0] rd,
                         input logic re, input logic [7:0] ec, input logic rr,
                         input bit prev, input bit have, input exp_t e);
    if (prev) chk({nm, "_ready_after_done"}, rr, 1);
    if (rv) begin
      if (!have) chk({nm, "_unexpected_rsp"}, rv, 0);
      else begin
        chk({nm, "_rsp_data"}, rd, e.data);
        chk({nm, "_rsp_err"}, re, e.err);
        chk({nm, "_err_cnt"}, ec, e.cnt);
        chk({nm, "_rsp_cycle"}, 64'(cyc), 64'(e.cyc));
        chk({nm, "_ready_in_done"}, rr, 0);
      end
    end
  endtask

  // Response monitor
  initial begin
    bit pa, pb, ha, hb;
    exp_t ea, eb;
    pa = 0; pb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pa = 0; pb = 0;
      end else begin
        ha = rv_a && qa.size() != 0;
        hb = rv_b && qb.size() != 0;
        if (ha) ea = qa.pop_front();
        if (hb) eb = qb.pop_front();
        chk_rsp("a", rv_a, rd_a, re_a, ec_a, ready_a, pa, ha, ea);
        chk_rsp("b", rv_b, rd_b, re_b, ec_b, ready_b, pb, hb, eb);
        pa = rv_a; pb = rv_b;
      end
    end
  end

  // Target emulation, driven from instance a's request side, with random
  // noise on every input the crossbar must ignore.
  initial begin
    int phase, vcnt, rcnt, oth;
    phase = 0; vcnt = 0; rcnt = 0;
    tgt_ready = '0; tgt_rsp_valid = '0; tgt_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
        tgt_ready = '0;
        tgt_rsp_valid = '0;
      end else begin
        oth = 1 - cur_sel;
        tgt_rsp_data = {$urandom, $urandom};
        tgt_ready = NT'($urandom);
        tgt_rsp_valid = NT'($urandom) & NT'($urandom);
        if (phase == 0 && tv_a != '0) begin
          phase = 1;
          vcnt = 0;
        end
        if (phase == 1) begin
          if (tv_a == '0) phase = 0;
          else begin
            chk("tgt_valid", tv_a, cur_hit ? (64'd1 << cur_sel) : 64'd0);
            chk("tgt_addr", taddr_a, cur_addr);
            chk("tgt_data_wren_mask", {tdata_a, twren_a, tmask_a}, {cur_data, cur_wren, cur_mask});
            tgt_ready[cur_sel] = (vcnt == plan_rd);
            if (force_spur) begin
              tgt_ready[oth] = 1'b1;
              tgt_rsp_valid[oth] = 1'b1;
            end
            if (vcnt == plan_rd) begin
              phase = 2;
              rcnt = 0;
            end else vcnt++;
          end
        end else if (phase == 2) begin
          if (rcnt == 0) chk("tgt_valid_drop", tv_a, 0);
          rcnt++;
          tgt_rsp_valid[cur_sel] = 1'b0;
          if (force_spur) begin
            tgt_ready[oth] = 1'b1;
            tgt_rsp_valid[oth] = 1'b1;
          end
          if (ready_a) phase = 0;
          else if (!plan_never && rcnt == plan_rspd) begin
            tgt_rsp_valid[cur_sel] = 1'b1;
            tgt_rsp_data[cur_sel*DW +: DW] = plan_data;
            phase = 0;
          end
        end
      end
    end
  end

  task automatic chk_reset_state(input string nm);
    chk({nm, "_a_ctl"}, {rv_a, re_a, ec_a, tv_a, ready_a}, {1'b0, 1'b0, 8'h0, 2'b00, 1'b1});
    chk({nm, "_a_dat"}, {rd_a, tdata_a}, 64'h0);
    chk({nm, "_a_tgt"}, {taddr_a, twren_a, tmask_a}, 64'h0);
    chk({nm, "_b_ctl"}, {rv_b, re_b, ec_b, tv_b, ready_b}, {1'b0, 1'b0, 8'h0, 2'b00, 1'b1});
    chk({nm, "_b_dat"}, {rd_b, tdata_b}, 64'h0);
    chk({nm, "_b_tgt"}, {taddr_b, twren_b, tmask_b}, 64'h0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] bnd [6];
    logic [AW-1:0] a;
    int r;
    bnd = '{30'h00003FF, 30'h0000400, 30'h20000FF, 30'h2000100, 30'h1FFFFFF, 30'h0000000};
    rst_n = 1'b0; req_valid = 1'b0; addr = '0; wdata = '0; wren = 1'b0; mask = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read hit on target 0, immediate ready and response
    issue(30'h0000010, 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 32'hCAFEBABE, 1'b1);
    // Write hit on target 1, ready delayed three cycles
    issue(30'h2000004, 32'h000000A5, 1'b1, 4'b0001, 3, 1, 1'b0, 32'h12345678, 1'b1);
    // Decode miss
    issue(30'h1000000, 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 32'h0, 1'b1);
    // Target never responds: both instances time out
    issue(30'h0000020, 32'h0, 1'b0, 4'hF, 0, 1, 1'b1, 32'h0, 1'b1);
    // Region bounds
    issue(30'h00003FF, 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 32'h11112222, 1'b1);
    issue(30'h0000400, 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 32'h33334444, 1'b1);
    issue(30'h20000FF, 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 32'h55556666, 1'b1);
    // Non-selected target driving ready and response continuously
    force_spur = 1'b1;
    issue(30'h0000100, 32'h0, 1'b0, 4'hF, 1, 2, 1'b0, 32'hA5A55A5A, 1'b1);
    force_spur = 1'b0;

    // Reset while waiting in RSP: no response may follow
    issue(30'h0000030, 32'h0, 1'b0, 4'hF, 0, 1, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("async_reset");
    ecnt = '{0, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_err_cnt", {ec_a, ec_b}, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: a = AW'($urandom_range(0, 32'h3FF));
        4, 5, 6:    a = 30'h2000000 + AW'($urandom_range(0, 32'hFF));
        7:          a = AW'($urandom);
        8:          a = bnd[$urandom_range(0, 5)];
        default:    a = 30'h3FFFFFFF;
      endcase
      issue(a, $urandom, 1'($urandom), MW'($urandom), $urandom_range(0, 4),
            $urandom_range(1, 5), ($urandom_range(0, 39) == 0), $urandom, 1'b1);
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++)
      issue(30'h1000000 + AW'(i), 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("err_cnt_saturated", {ec_a, ec_b}, 16'hFFFF);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
